// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous 32-bit ROM between an instruction-fetch
// port and a data-load port.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   if_req_i / if_addr_i        fetch request and byte address (held until grant)
//   if_gnt_o                    fetch request accepted this cycle
//   if_rvalid_o / if_rdata_o    fetch response pulse and word, one cycle after grant
//   if_err_o                    fetch response is an error (qualified by rvalid)
//   d_*                         data-load port, same meaning as the fetch port
//   mem_en_o / mem_addr_o       ROM read strobe and word index
//   mem_rdata_i                 ROM read word, valid one cycle after mem_en_o
//
// Data wins contention until fetch has waited through STARVE_LIMIT consecutive
// data grants; fetch then takes the next slot.
module rom_arbiter #(
  parameter int unsigned DEPTH_WORDS  = 16384,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           if_req_i,
  input  logic [31:0]                    if_addr_i,
  output logic                           if_gnt_o,
  output logic                           if_rvalid_o,
  output logic [31:0]                    if_rdata_o,
  output logic                           if_err_o,
  input  logic                           d_req_i,
  input  logic [31:0]                    d_addr_i,
  output logic                           d_gnt_o,
  output logic                           d_rvalid_o,
  output logic [31:0]                    d_rdata_o,
  output logic                           d_err_o,
  output logic                           mem_en_o,
  output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr_o,
  input  logic [31:0]                    mem_rdata_i
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  LIMIT = 2'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } owner_e;

  owner_e          gnt_sel;
  owner_e          owner_q, owner_d;
  logic            err_q, err_d;
  logic [1:0]      starve_q, starve_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     if_rdata_q, d_rdata_q;
  logic [31:0]     sel_addr;
  logic            sel_legal;
  logic [31:0]     resp_data;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a} < (34'(DEPTH_WORDS) << 2));
  endfunction

  // Arbitration and ROM strobe; grants are forced low while rst is high so the
  // outputs clear asynchronously along with the registers.
  always_comb begin
    gnt_sel = OWN_NONE;
    if (!rst) begin
      if (if_req_i && d_req_i) gnt_sel = (starve_q == LIMIT) ? OWN_IF : OWN_D;
      else if (if_req_i)       gnt_sel = OWN_IF;
      else if (d_req_i)        gnt_sel = OWN_D;
    end

    sel_addr   = (gnt_sel == OWN_IF) ? if_addr_i : d_addr_i;
    sel_legal  = (gnt_sel != OWN_NONE) && addr_legal(sel_addr);

    if_gnt_o   = (gnt_sel == OWN_IF);
    d_gnt_o    = (gnt_sel == OWN_D);
    mem_en_o   = sel_legal;
    mem_addr_d = sel_legal ? sel_addr[AW+1:2] : mem_addr_q;
    mem_addr_o = mem_addr_d;

    owner_d    = gnt_sel;
    err_d      = (gnt_sel != OWN_NONE) && !sel_legal;

    // Counts data grants that fetch sat through; any idle-fetch cycle restarts it.
    if (!if_req_i || gnt_sel == OWN_IF)           starve_d = '0;
    else if (gnt_sel == OWN_D && starve_q != LIMIT) starve_d = 2'(starve_q + 2'd1);
    else                                           starve_d = starve_q;
  end

  // Response routing depends only on the registered owner of the in-flight read;
  // the idle port keeps presenting its last word.
  always_comb begin
    resp_data   = err_q ? '0 : mem_rdata_i;
    if_rvalid_o = (owner_q == OWN_IF);
    d_rvalid_o  = (owner_q == OWN_D);
    if_err_o    = if_rvalid_o && err_q;
    d_err_o     = d_rvalid_o && err_q;
    if_rdata_o  = if_rvalid_o ? resp_data : if_rdata_q;
    d_rdata_o   = d_rvalid_o ? resp_data : d_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      err_q      <= 1'b0;
      starve_q   <= '0;
      mem_addr_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      err_q      <= err_d;
      starve_q   <= starve_d;
      mem_addr_q <= mem_addr_d;
      if_rdata_q <= if_rdata_o;
      d_rdata_q  <= d_rdata_o;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus random traffic,
// compared against a cycle-level reference model of the arbitration rules.
module tb_rom_arbiter;

  localparam int DEPTH = 16384;
  localparam int LIMIT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0;
  logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  logic [31:0] rom [DEPTH];

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_cnt;
  int          m_pend;      // 0 none, 1 fetch, 2 data
  bit          m_perr;
  int          m_pidx;
  logic [31:0] m_last_if, m_last_d;
  int          m_last_ma;
  int          obs_g;       // observed grant of the latest step: 0/1(IF)/2(D)

  rom_arbiter #(.DEPTH_WORDS(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_gnt_o(d_gnt),
    .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // synchronous ROM: word appears the cycle after the strobe
  always @(posedge clk) if (mem_en) mem_rdata <= rom[mem_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 4 * DEPTH);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pend = 0; m_perr = 0; m_pidx = 0;
    m_last_if = '0; m_last_d = '0; m_last_ma = 0;
  endtask

  // One clock cycle: drive requests, check against the model, advance the model.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
    int          g;
    logic [31:0] ga, rdat;
    bit          gl;
    @(negedge clk);
    if_req = ir; if_addr = ia; d_req = dr; d_addr = da;
    #1;
    if (ir && dr) g = (m_cnt == LIMIT) ? 1 : 2;
    else if (ir)  g = 1;
    else if (dr)  g = 2;
    else          g = 0;
    ga = (g == 1) ? ia : da;
    gl = (g != 0) && legal(ga);
    obs_g = if_gnt ? 1 : (d_gnt ? 2 : 0);

    check("if_gnt", if_gnt, g == 1);
    check("d_gnt", d_gnt, g == 2);
    check("mem_en", mem_en, gl);
    check("mem_addr", mem_addr, gl ? (ga / 4) : m_last_ma);

    rdat = m_perr ? 32'h0 : rom[m_pidx];
    check("if_rvalid", if_rvalid, m_pend == 1);
    check("if_err", if_err, m_pend == 1 && m_perr);
    check("if_rdata", if_rdata, (m_pend == 1) ? rdat : m_last_if);
    check("d_rvalid", d_rvalid, m_pend == 2);
    check("d_err", d_err, m_pend == 2 && m_perr);
    check("d_rdata", d_rdata, (m_pend == 2) ? rdat : m_last_d);

    if (m_pend == 1) m_last_if = rdat;
    if (m_pend == 2) m_last_d  = rdat;
    m_pend = g;
    m_perr = (g != 0) && !gl;
    m_pidx = gl ? ga / 4 : 0;
    if (gl) m_last_ma = ga / 4;
    if (!ir || g == 1)             m_cnt = 0;
    else if (g == 2 && m_cnt < LIMIT) m_cnt = m_cnt + 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {if_gnt, d_gnt}, 2'b00);
    check({tag, "_rvalid"}, {if_rvalid, d_rvalid}, 2'b00);
    check({tag, "_err"}, {if_err, d_err}, 2'b00);
    check({tag, "_rdata"}, {if_rdata, d_rdata}, 64'h0);
    check({tag, "_mem"}, {mem_en, mem_addr}, 15'h0);
  endtask

  initial begin
    int exp_order [6];
    int rnd_addr;
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    rom[4] = 32'hDEADBEEF;
    model_reset();

    // reset with both requests active: everything must stay low
    if_req = 1'b1; d_req = 1'b1;
    #12;
    check_all_zero("rst_init");
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;

    // single fetch of word 4
    step(1, 32'h10, 0, 0);
    check("single_mem_addr", mem_addr, 14'd4);
    step(0, 0, 0, 0);
    check("single_rdata", if_rdata, 32'hDEADBEEF);
    step(0, 0, 0, 0);

    // sustained contention
    exp_order = '{2, 2, 1, 2, 2, 1};
    for (int i = 0; i < 6; i++) begin
      step(1, 32'h40 + 4 * i, 1, 32'h100 + 4 * i);
      check("contend_order", obs_g, exp_order[i]);
    end
    step(0, 0, 0, 0);

    // illegal addresses: out of range and unaligned
    step(0, 0, 1, 32'h0001_0000);
    step(0, 0, 1, 32'h6);
    check("illegal_err", {d_rvalid, d_err, d_rdata}, {2'b11, 32'h0});
    step(0, 0, 0, 0);
    check("illegal2_err", {d_rvalid, d_err, d_rdata}, {2'b11, 32'h0});

    // streaming fetch
    step(1, 32'h0, 0, 0);
    step(1, 32'h4, 0, 0);
    step(1, 32'h8, 0, 0);
    step(0, 0, 0, 0);
    check("stream_last", if_rdata, rom[2]);

    // starvation counter restart when fetch drops for a cycle
    step(1, 32'h20, 1, 32'h200);
    step(0, 32'h20, 1, 32'h204);
    step(1, 32'h20, 1, 32'h208);
    check("starve_d1", obs_g, 2);
    step(1, 32'h20, 1, 32'h20C);
    check("starve_d2", obs_g, 2);
    step(1, 32'h20, 1, 32'h210);
    check("starve_if", obs_g, 1);
    step(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a0, a1;
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 5))
          0:       rnd_addr = $urandom;
          1:       rnd_addr = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
          default: rnd_addr = $urandom_range(0, DEPTH - 1) * 4;
        endcase
        if (k == 0) a0 = rnd_addr; else a1 = rnd_addr;
      end
      step(1'($urandom_range(0, 1)), a0, 1'($urandom_range(0, 1)), a1);
    end
    step(0, 0, 0, 0);

    // reset while a data read is in flight
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h30; if_req = 1'b0;
    #1;
    check("midrst_gnt", d_gnt, 1'b1);
    @(posedge clk);
    #1;
    check("midrst_rvalid_pre", d_rvalid, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0;
    model_reset();
    step(0, 0, 0, 0);
    step(1, 32'h10, 0, 0);
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter DEPTH_WORDS, default 16384, ROM depth in 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
REQ-002 Parameter STARVE_LIMIT, default 2, maximum consecutive data grants while fetch is waiting.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 if_req  in  1  instruction-fetch read request; held with if_addr until if_gnt.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  fetch response valid; one cycle pulse.
REQ-009 if_rdata  out  32  fetch response word.
REQ-010 if_err  out  1  fetch response is an error; qualified by if_rvalid.
REQ-011 d_req, d_addr, d_gnt, d_rvalid, d_rdata, d_err: data-load port, same widths and rules as REQ-005..REQ-010.
REQ-012 mem_en  out  1  ROM read strobe.
REQ-013 mem_addr  out  14  ROM word index, log2(DEPTH_WORDS) bits.
REQ-014 mem_rdata  in  32  ROM read data, valid exactly 1 cycle after mem_en.

Function
REQ-015 Arbitration is combinational on the current cycle's requests; at most one grant per cycle.
REQ-016 Only one port requesting: that port is granted.
REQ-017 Both ports requesting: data is granted, unless starve_cnt == STARVE_LIMIT, in which case fetch is granted.
REQ-018 starve_cnt, 2 bits: +1 on a data grant while if_req=1; cleared on any fetch grant or on any cycle with if_req=0; saturates at STARVE_LIMIT.
REQ-019 Legal request means addr[1:0]==0 and addr < 4*DEPTH_WORDS.
REQ-020 Granted legal request: mem_en=1 and mem_addr=addr[15:2] in the grant cycle.
REQ-021 Granted illegal request: mem_en=0; the grant and response timing are otherwise identical to a legal request.
REQ-022 Response latency is exactly 1 cycle: a grant in cycle N gives the same port's rvalid=1 in cycle N+1.
REQ-023 Response data: rdata=mem_rdata and err=0 for legal requests; rdata=0 and err=1 for illegal requests.
REQ-024 Owner and error flag of the in-flight request are registered in the grant cycle; the response routes by that register only, never by current requests.
REQ-025 Back-to-back grants are allowed every cycle, to either port, with no bubble; a new grant may coincide with the previous response.
REQ-026 No response backpressure; requesters accept rvalid unconditionally.
REQ-027 Non-owner port outputs: rvalid=0, err=0, rdata held at its last value.
REQ-028 No grant in a cycle: mem_en=0, and mem_addr holds its previous value.

Reset
REQ-029 While rst=1, and immediately on assertion: if_gnt=d_gnt=0, if_rvalid=d_rvalid=0, if_err=d_err=0, if_rdata=d_rdata=0, mem_en=0, mem_addr=0, starve_cnt=0, in-flight flag cleared.
REQ-030 Reset mid-operation drops any in-flight response; no rvalid is produced for it after rst deasserts.
REQ-031 First grant is possible in the first rising edge cycle after rst deasserts.

Verification
REQ-032 Reset: assert rst mid-cycle with d_req=1 pending -> all outputs 0 asynchronously; no d_rvalid in the cycle after release.
REQ-033 Single fetch: if_req=1, if_addr=0x10, ROM word 4 = 0xDEADBEEF -> if_gnt in cycle N, mem_addr=4, if_rvalid=1 and if_rdata=0xDEADBEEF in N+1, if_err=0.
REQ-034 Contention: if_req=d_req=1 held continuously -> grant order D, D, IF, D, D, IF; every response arrives exactly 1 cycle after its grant on the correct port.
REQ-035 Illegal addresses: d_addr=0x0001_0000 -> d_gnt=1, mem_en=0, then d_rvalid=1, d_err=1, d_rdata=0; d_addr=0x6 -> same error response.
REQ-036 Streaming: fetch addresses 0x0, 0x4, 0x8 on consecutive cycles -> three grants, then three rvalid pulses on consecutive cycles with data of words 0, 1, 2.
REQ-037 Starvation reset: data streaming continuously, if_req dropped for one cycle and then re-raised -> starve_cnt clears and fetch is granted after 2 further data grants.
